data_bus_arbiter: RTL and testbench

//  Shares the single data_memory port between two masters: port 0 = core load/store,

---
 rtl/data_bus_arbiter_if.sv | 54 +++++
 rtl/data_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_data_bus_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_arbiter_if.sv
// Bundle of both requester ports, the data_memory port and arbiter status.
// The arbiter uses the slave view; the requesters plus memory use the master view.
interface data_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [2:0]        m0_funct3;
  logic              m0_gnt;
  logic              m0_done;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [2:0]        m1_funct3;
  logic              m1_gnt;
  logic              m1_done;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_funct3;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              owner;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_funct3,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_funct3,
    input  mem_rdata,
    output m0_gnt, m0_done, m0_rdata,
    output m1_gnt, m1_done, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_funct3,
    output busy, owner
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_funct3,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_funct3,
    output mem_rdata,
    input  m0_gnt, m0_done, m0_rdata,
    input  m1_gnt, m1_done, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_funct3,
    input  busy, owner
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the single data_memory port: fixed priority to port 0
// with a starvation guard for port 1, one transaction in flight at a time.
module data_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 0,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  data_bus_arbiter_if.slave bus
);
  localparam int            SW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT     = SW'(STARVE_LIMIT);
  localparam logic [3:0]    WAIT_LOAD = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;
  localparam bit            COMB_READ = (MEM_LATENCY == 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state, state_nxt;
  logic [3:0]        lat_cnt, lat_cnt_nxt;
  logic [SW-1:0]     starve_cnt;
  logic              grant, grant_port, issue, finish;

  logic              we_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [2:0]        funct3_p1;
  logic              owner_p1;
  logic              done0_p2, done1_p2;
  logic [DATA_W-1:0] rdata0_p2, rdata1_p2;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == LIMIT) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    grant       = 1'b0;
    grant_port  = 1'b0;
    issue       = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        // Grants are held off while reset is asserted so outputs stay quiet.
        if (rst && (bus.m0_req || bus.m1_req)) begin
          grant      = 1'b1;
          grant_port = bus.m1_req && (!bus.m0_req || starve_cnt == LIMIT);
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        if (we_p1 || COMB_READ) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else begin
          lat_cnt_nxt = WAIT_LOAD;
          state_nxt   = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == 4'd0) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else begin
          lat_cnt_nxt = lat_cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
      we_p1      <= 1'b0;
      addr_p1    <= '0;
      wdata_p1   <= '0;
      funct3_p1  <= '0;
      owner_p1   <= 1'b0;
      done0_p2   <= 1'b0;
      done1_p2   <= 1'b0;
      rdata0_p2  <= '0;
      rdata1_p2  <= '0;
    end else begin
      // p1: winner's request captured at grant, drives the memory port
      if (grant) begin
        we_p1     <= grant_port ? bus.m1_we     : bus.m0_we;
        addr_p1   <= grant_port ? bus.m1_addr   : bus.m0_addr;
        wdata_p1  <= grant_port ? bus.m1_wdata  : bus.m0_wdata;
        funct3_p1 <= grant_port ? bus.m1_funct3 : bus.m0_funct3;
        owner_p1  <= grant_port;
      end
      if (state == IDLE) begin
        if (!bus.m1_req || (grant && grant_port)) starve_cnt <= '0;
        else if (grant)                           starve_cnt <= sat_inc(starve_cnt);
      end
      // p2: completion pulse and load data returned to the owning port
      done0_p2 <= finish && !owner_p1;
      done1_p2 <= finish &&  owner_p1;
      if (finish && !we_p1) begin
        if (owner_p1) rdata1_p2 <= bus.mem_rdata;
        else          rdata0_p2 <= bus.mem_rdata;
      end
    end
  end

  assign bus.m0_gnt     = grant && !grant_port;
  assign bus.m1_gnt     = grant &&  grant_port;
  assign bus.m0_done    = done0_p2;
  assign bus.m1_done    = done1_p2;
  assign bus.m0_rdata   = rdata0_p2;
  assign bus.m1_rdata   = rdata1_p2;
  assign bus.mem_en     = issue;
  assign bus.mem_we     = issue && we_p1;
  assign bus.mem_addr   = addr_p1;
  assign bus.mem_wdata  = wdata_p1;
  assign bus.mem_funct3 = funct3_p1;
  assign bus.busy       = (state != IDLE);
  assign bus.owner      = owner_p1;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: a zero-latency and a three-cycle-latency
// instance share one stimulus; a select picks which instance is observed.
module tb_data_bus_arbiter;
  typedef struct packed {
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [2:0]  m0_f3;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [2:0]  m1_f3;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic        en;
    logic        we;
    logic        busy;
    logic        owner;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } out_t;

  typedef struct {
    in_t  stim;
    out_t want;
  } vec_t;

  logic clk;
  logic rst;
  logic lat3;
  in_t  drv;
  out_t a0, a3, act;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[12];
  int   order[10];
  int   n;

  data_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  data_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(0), .STARVE_LIMIT(4))
    dut_l0 (.clk(clk), .rst(rst), .bus(b0));
  data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4))
    dut_l3 (.clk(clk), .rst(rst), .bus(b3));

  assign b0.m0_req = drv.m0_req;     assign b3.m0_req = drv.m0_req;
  assign b0.m0_we = drv.m0_we;       assign b3.m0_we = drv.m0_we;
  assign b0.m0_addr = drv.m0_addr;   assign b3.m0_addr = drv.m0_addr;
  assign b0.m0_wdata = drv.m0_wdata; assign b3.m0_wdata = drv.m0_wdata;
  assign b0.m0_funct3 = drv.m0_f3;   assign b3.m0_funct3 = drv.m0_f3;
  assign b0.m1_req = drv.m1_req;     assign b3.m1_req = drv.m1_req;
  assign b0.m1_we = drv.m1_we;       assign b3.m1_we = drv.m1_we;
  assign b0.m1_addr = drv.m1_addr;   assign b3.m1_addr = drv.m1_addr;
  assign b0.m1_wdata = drv.m1_wdata; assign b3.m1_wdata = drv.m1_wdata;
  assign b0.m1_funct3 = drv.m1_f3;   assign b3.m1_funct3 = drv.m1_f3;
  assign b0.mem_rdata = drv.mem_rdata; assign b3.mem_rdata = drv.mem_rdata;

  assign a0 = {b0.m0_gnt, b0.m1_gnt, b0.m0_done, b0.m1_done, b0.mem_en, b0.mem_we, b0.busy,
               b0.owner, b0.mem_addr, b0.mem_wdata, b0.mem_funct3, b0.m0_rdata, b0.m1_rdata};
  assign a3 = {b3.m0_gnt, b3.m1_gnt, b3.m0_done, b3.m1_done, b3.mem_en, b3.mem_we, b3.busy,
               b3.owner, b3.mem_addr, b3.mem_wdata, b3.mem_funct3, b3.m0_rdata, b3.m1_rdata};
  assign act = lat3 ? a3 : a0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string nm, input out_t got, input out_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic chk1(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  initial begin
    // stim: m0 {req,we,addr,wdata,f3}, m1 {req,we,addr,wdata,f3}, mem_rdata
    // want: gnt0,gnt1,done0,done1,en,we,busy,owner, addr,wdata,f3, rd0,rd1
    vecs[0]  = '{'{1'b1,1'b0,32'h100,32'h0,3'd2, 1'b0,1'b0,32'h0,32'h0,3'd0, 32'hDEADBEEF},
                 '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,3'd0, 32'h0,32'h0}};
    vecs[1]  = '{'{1'b0,1'b0,32'h100,32'h0,3'd2, 1'b0,1'b0,32'h0,32'h0,3'd0, 32'hDEADBEEF},
                 '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 32'h100,32'h0,3'd2, 32'h0,32'h0}};
    vecs[2]  = '{'{1'b0,1'b0,32'h100,32'h0,3'd2, 1'b0,1'b0,32'h0,32'h0,3'd0, 32'hDEADBEEF},
                 '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h100,32'h0,3'd2, 32'hDEADBEEF,32'h0}};
    vecs[3]  = '{'{1'b1,1'b1,32'h200,32'h11111111,3'd2, 1'b1,1'b0,32'h300,32'h0,3'd2, 32'h0},
                 '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h100,32'h0,3'd2, 32'hDEADBEEF,32'h0}};
    vecs[4]  = '{'{1'b0,1'b1,32'h200,32'h11111111,3'd2, 1'b1,1'b0,32'h300,32'h0,3'd2, 32'h0},
                 '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0, 32'h200,32'h11111111,3'd2, 32'hDEADBEEF,32'h0}};
    vecs[5]  = '{'{1'b0,1'b1,32'h200,32'h11111111,3'd2, 1'b1,1'b0,32'h300,32'h0,3'd2, 32'hCAFEF00D},
                 '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h200,32'h11111111,3'd2, 32'hDEADBEEF,32'h0}};
    vecs[6]  = '{'{1'b0,1'b1,32'h200,32'h11111111,3'd2, 1'b0,1'b0,32'h300,32'h0,3'd2, 32'hCAFEF00D},
                 '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1, 32'h300,32'h0,3'd2, 32'hDEADBEEF,32'h0}};
    vecs[7]  = '{'{1'b0,1'b1,32'h200,32'h11111111,3'd2, 1'b0,1'b0,32'h300,32'h0,3'd2, 32'h0},
                 '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 32'h300,32'h0,3'd2, 32'hDEADBEEF,32'hCAFEF00D}};
    vecs[8]  = '{'{1'b1,1'b1,32'h203,32'hAB,3'd0, 1'b0,1'b0,32'h300,32'h0,3'd2, 32'h0},
                 '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h300,32'h0,3'd2, 32'hDEADBEEF,32'hCAFEF00D}};
    vecs[9]  = '{'{1'b0,1'b1,32'h203,32'hAB,3'd0, 1'b0,1'b0,32'h300,32'h0,3'd2, 32'h0},
                 '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0, 32'h203,32'hAB,3'd0, 32'hDEADBEEF,32'hCAFEF00D}};
    vecs[10] = '{'{1'b0,1'b1,32'h203,32'hAB,3'd0, 1'b0,1'b0,32'h300,32'h0,3'd2, 32'h0},
                 '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h203,32'hAB,3'd0, 32'hDEADBEEF,32'hCAFEF00D}};
    vecs[11] = '{'{1'b0,1'b1,32'h203,32'hAB,3'd0, 1'b0,1'b0,32'h300,32'h0,3'd2, 32'h0},
                 '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h203,32'hAB,3'd0, 32'hDEADBEEF,32'hCAFEF00D}};
    order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    drv  = '0;
    rst  = 1'b0;
    lat3 = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("reset_lat0", act, '0);
    lat3 = 1'b1;
    #1 chk("reset_lat3", act, '0);
    lat3 = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Single load, contended store/load, byte store at zero latency.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drv = vecs[i].stim;
      #1 chk($sformatf("vec%0d", i), act, vecs[i].want);
    end

    // Starvation guard: both ports request continuously.
    @(negedge clk);
    drv = '0;
    drv.m0_req = 1'b1; drv.m0_addr = 32'h10;
    drv.m1_req = 1'b1; drv.m1_addr = 32'h20;
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
      #1;
      if (act.gnt0 || act.gnt1) begin
        chk1($sformatf("starve_grant%0d", n), {31'd0, act.gnt1}, order[n]);
        n++;
      end
      if (n < 10) @(negedge clk);
    end
    if (n < 10) begin
      checks++;
      errors++;
      $display("FAIL starve_timeout: got %0d grants want 10", n);
    end
    @(negedge clk);
    drv = '0;
    repeat (3) @(negedge clk);

    // Three-cycle latency load then store on port 1.
    rst = 1'b0;
    lat3 = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drv.m1_req = 1'b1; drv.m1_we = 1'b0; drv.m1_addr = 32'h400; drv.m1_f3 = 3'd2;
    drv.mem_rdata = 32'h1000;
    #1 chk1("lat3_load_gnt", {31'd0, act.gnt1}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      drv.m1_req = 1'b0;
      drv.mem_rdata = 32'h1000 + k;
      #1 chk1($sformatf("lat3_load_k%0d", k), {29'd0, act.en, act.done1, act.busy},
              {29'd0, (k == 1), (k == 5), (k >= 1 && k <= 4)});
    end
    chk1("lat3_load_rdata", act.rd1, 32'h1004);
    @(negedge clk);
    drv.m1_req = 1'b1; drv.m1_we = 1'b1; drv.m1_addr = 32'h404; drv.m1_wdata = 32'h55;
    #1 chk1("lat3_store_gnt", {31'd0, act.gnt1}, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      drv.m1_req = 1'b0;
      #1 chk1($sformatf("lat3_store_k%0d", k), {29'd0, act.en, act.we, act.done1},
              {29'd0, (k == 1), (k == 1), (k == 2)});
    end
    chk1("lat3_store_rdata_kept", act.rd1, 32'h1004);

    // Reset in the middle of a wait abandons the access.
    @(negedge clk);
    drv = '0;
    drv.m0_req = 1'b1; drv.m0_addr = 32'h500; drv.m0_f3 = 3'd2;
    #1 chk1("rst_mid_gnt", {31'd0, act.gnt0}, 32'd1);
    @(negedge clk);
    drv.m0_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("rst_wait_clear", act, '0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_no_done", act, '0);
    @(negedge clk);
    drv.m0_req = 1'b1; drv.m0_addr = 32'h600; drv.mem_rdata = 32'h2000;
    #1 chk1("post_rst_gnt", {31'd0, act.gnt0}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      drv.m0_req = 1'b0;
      drv.mem_rdata = 32'h2000 + k;
      #1 chk1($sformatf("post_rst_k%0d", k), {29'd0, act.en, act.done0, act.busy},
              {29'd0, (k == 1), (k == 5), (k >= 1 && k <= 4)});
    end
    chk1("post_rst_rdata", act.rd0, 32'h2004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
